// File: rtl/video_line_fetch_ctrl_if.sv
// Frame-buffer burst read channel between the line fetch controller (master)
// and the memory read engine (slave).
interface video_line_fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 24
) ();
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [15:0]           rd_len;
  logic                  rd_ack;
  logic                  rd_done;

  modport master (
    output rd_req,
    output rd_addr,
    output rd_len,
    input  rd_ack,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    input  rd_len,
    output rd_ack,
    output rd_done
  );
endinterface

// File: rtl/video_line_fetch_ctrl.sv
// Per-line frame-buffer read scheduler for the display path.
// Picks the last completed frame on each vs rising edge, then issues one burst
// per active line while staying at most PREFETCH_LINES ahead of consumption.
// Optional macro VLFC_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module video_line_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned LINE_WORDS     = 1280,
  parameter int unsigned V_LINES        = 720,
  parameter int unsigned FRAME_NUM      = 3,
  parameter int unsigned FB_BASE        = 0,
  parameter int unsigned PREFETCH_LINES = 2
) (
  input  logic                      video_clk,
  input  logic                      rst_n,
  input  logic                      vs,
  input  logic                      de,
  input  logic [1:0]                wr_frame_idx,
  video_line_fetch_ctrl_if.master   rd_if,
  output logic [1:0]                rd_frame_idx,
  output logic                      busy,
  output logic                      err_underflow
`ifdef VLFC_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]               underflow_cnt
`endif
);

  localparam int unsigned CW  = $clog2(V_LINES + 1);
  localparam int unsigned CWE = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] FrameWords = ADDR_WIDTH'(LINE_WORDS * V_LINES);
  localparam logic [ADDR_WIDTH-1:0] LineWords  = ADDR_WIDTH'(LINE_WORDS);
  localparam logic [CW-1:0]         LastLine   = CW'(V_LINES);

  typedef enum logic [2:0] {StIdle, StLoad, StReq, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic                    vs_q, vs_qq, de_q, de_qq;
  logic                    rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              rd_frame_idx_q, rd_frame_idx_d;
  logic [CW-1:0]           fetch_cnt_q, fetch_cnt_d;
  logic [CW-1:0]           done_cnt_q, done_cnt_d;
  logic [CW-1:0]           cons_cnt_q, cons_cnt_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    pend_q, pend_d;
  logic [1:0]              pend_idx_q, pend_idx_d;

  logic                    vs_rise, de_rise, de_fall, uf_event;
  logic [2:0]              idx_sum;
  logic [1:0]              start_idx;
  logic [ADDR_WIDTH-1:0]   frame_base;
  logic                    room;
  logic                    apply;
  logic [1:0]              apply_idx;

  assign vs_rise  = vs_q & ~vs_qq;
  assign de_rise  = de_q & ~de_qq;
  assign de_fall  = ~de_q & de_qq;
  assign uf_event = de_rise && (done_cnt_q <= cons_cnt_q);
  // Widened compare so consumption running ahead of fetch cannot wrap.
  assign room     = {1'b0, fetch_cnt_q} < ({1'b0, cons_cnt_q} + CWE'(PREFETCH_LINES));

  // Newest completed frame: one behind the writer, modulo FRAME_NUM.
  always_comb begin
    idx_sum = {1'b0, wr_frame_idx} + 3'(FRAME_NUM - 1);
    if (idx_sum >= 3'(FRAME_NUM)) idx_sum = idx_sum - 3'(FRAME_NUM);
    if (idx_sum >= 3'(FRAME_NUM)) idx_sum = idx_sum - 3'(FRAME_NUM);
    start_idx = idx_sum[1:0];
  end

  // Frame base by repeated addition of the frame size; avoids a multiplier.
  always_comb begin
    frame_base = ADDR_WIDTH'(FB_BASE);
    for (int i = 1; i < 4; i++) begin
      if (int'(rd_frame_idx_q) >= i) frame_base = frame_base + FrameWords;
    end
  end

  // Next-state logic for the fetch FSM, counters and flags.
  always_comb begin
    state_d        = state_q;
    rd_req_d       = rd_req_q;
    addr_d         = addr_q;
    rd_frame_idx_d = rd_frame_idx_q;
    fetch_cnt_d    = fetch_cnt_q;
    done_cnt_d     = done_cnt_q;
    cons_cnt_d     = cons_cnt_q;
    busy_d         = busy_q;
    err_d          = err_q;
    pend_d         = pend_q;
    pend_idx_d     = pend_idx_q;
    apply          = 1'b0;
    apply_idx      = start_idx;

    if (de_fall && (cons_cnt_q != LastLine)) cons_cnt_d = cons_cnt_q + CW'(1);
    if (vs_rise) err_d = 1'b0;
    if (uf_event) err_d = 1'b1;

    unique case (state_q)
      StIdle, StHold: begin
        if (vs_rise) begin
          apply = 1'b1;
        end else if ((state_q == StHold) && room) begin
          state_d  = StReq;
          rd_req_d = 1'b1;
        end
      end
      StLoad: begin
        if (vs_rise) begin
          apply = 1'b1;
        end else begin
          addr_d   = frame_base;
          state_d  = StReq;
          rd_req_d = 1'b1;
        end
      end
      StReq: begin
        // A new frame start must not abandon an outstanding request.
        if (vs_rise) begin
          pend_d     = 1'b1;
          pend_idx_d = start_idx;
        end
        if (rd_if.rd_ack) begin
          rd_req_d    = 1'b0;
          fetch_cnt_d = fetch_cnt_q + CW'(1);
          addr_d      = addr_q + LineWords;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (vs_rise) begin
          pend_d     = 1'b1;
          pend_idx_d = start_idx;
        end
        if (rd_if.rd_done) begin
          done_cnt_d = done_cnt_q + CW'(1);
          if (pend_q || vs_rise) begin
            apply     = 1'b1;
            apply_idx = vs_rise ? start_idx : pend_idx_q;
          end else if (fetch_cnt_q == LastLine) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else if (room) begin
            state_d  = StReq;
            rd_req_d = 1'b1;
          end else begin
            state_d = StHold;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (apply) begin
      state_d        = StLoad;
      rd_req_d       = 1'b0;
      rd_frame_idx_d = apply_idx;
      fetch_cnt_d    = '0;
      done_cnt_d     = '0;
      cons_cnt_d     = '0;
      busy_d         = 1'b1;
      err_d          = 1'b0;
      pend_d         = 1'b0;
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      vs_q           <= 1'b0;
      vs_qq          <= 1'b0;
      de_q           <= 1'b0;
      de_qq          <= 1'b0;
      rd_req_q       <= 1'b0;
      addr_q         <= '0;
      rd_frame_idx_q <= '0;
      fetch_cnt_q    <= '0;
      done_cnt_q     <= '0;
      cons_cnt_q     <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      pend_q         <= 1'b0;
      pend_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      vs_q           <= vs;
      vs_qq          <= vs_q;
      de_q           <= de;
      de_qq          <= de_q;
      rd_req_q       <= rd_req_d;
      addr_q         <= addr_d;
      rd_frame_idx_q <= rd_frame_idx_d;
      fetch_cnt_q    <= fetch_cnt_d;
      done_cnt_q     <= done_cnt_d;
      cons_cnt_q     <= cons_cnt_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      pend_q         <= pend_d;
      pend_idx_q     <= pend_idx_d;
    end
  end

`ifdef VLFC_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Saturating underflow event count; survives vs, cleared only by reset.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (uf_event && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  // Underflow counter register.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) uf_cnt_q <= '0;
    else        uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_cnt = uf_cnt_q;
`else
  // Only the sticky err_underflow flag records underflow in this build.
`endif

  assign rd_if.rd_req  = rd_req_q;
  assign rd_if.rd_addr = addr_q;
  assign rd_if.rd_len  = 16'(LINE_WORDS);
  assign rd_frame_idx  = rd_frame_idx_q;
  assign busy          = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_video_line_fetch_ctrl.sv
// Directed bench for video_line_fetch_ctrl: LINE_WORDS=16, V_LINES=4,
// FRAME_NUM=3, FB_BASE=0x1000, PREFETCH_LINES=2.
module tb_video_line_fetch_ctrl;
  localparam int unsigned AW = 24;

  logic        video_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        vs        = 1'b0;
  logic        de        = 1'b0;
  logic [1:0]  wr_frame_idx = 2'd0;
  logic [1:0]  rd_frame_idx;
  logic        busy;
  logic        err_underflow;
`ifdef VLFC_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  video_line_fetch_ctrl_if #(.ADDR_WIDTH(AW)) rd_if ();

  video_line_fetch_ctrl #(
    .ADDR_WIDTH    (AW),
    .LINE_WORDS    (16),
    .V_LINES       (4),
    .FRAME_NUM     (3),
    .FB_BASE       (32'h1000),
    .PREFETCH_LINES(2)
  ) dut (
    .video_clk    (video_clk),
    .rst_n        (rst_n),
    .vs           (vs),
    .de           (de),
    .wr_frame_idx (wr_frame_idx),
    .rd_if        (rd_if),
    .rd_frame_idx (rd_frame_idx),
    .busy         (busy),
    .err_underflow(err_underflow)
`ifdef VLFC_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 video_clk = ~video_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge video_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req_chk(input logic [31:0] addr);
    for (int i = 0; i < 64; i++) begin
      if (rd_if.rd_req === 1'b1) break;
      tick(1);
    end
    chk("req_seen", 32'(rd_if.rd_req), 32'd1);
    chk("req_addr", 32'(rd_if.rd_addr), addr);
  endtask

  task automatic ack_after(input int n, input logic [31:0] addr);
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk("req_hold", 32'(rd_if.rd_req), 32'd1);
      chk("addr_hold", 32'(rd_if.rd_addr), addr);
    end
    rd_if.rd_ack = 1'b1;
    tick(1);
    rd_if.rd_ack = 1'b0;
    chk("req_drop", 32'(rd_if.rd_req), 32'd0);
  endtask

  task automatic done_after(input int n);
    tick(n);
    rd_if.rd_done = 1'b1;
    tick(1);
    rd_if.rd_done = 1'b0;
  endtask

  task automatic serve(input logic [31:0] addr, input int ack_dly, input int done_dly);
    wait_req_chk(addr);
    ack_after(ack_dly, addr);
    done_after(done_dly);
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
  endtask

  task automatic de_pulse();
    de = 1'b1;
    tick(3);
    de = 1'b0;
    tick(3);
  endtask

  initial begin
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    tick(2);
    // Reset values
    chk("rst_req", 32'(rd_if.rd_req), 32'd0);
    chk("rst_addr", 32'(rd_if.rd_addr), 32'h0);
    chk("rst_len", 32'(rd_if.rd_len), 32'd16);
    chk("rst_fidx", 32'(rd_frame_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: writer on 1 -> display frame 0; two lines prefetched then hold
    wr_frame_idx = 2'd1;
    vs_pulse();
    chk("s1_fidx", 32'(rd_frame_idx), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    serve(32'h1000, 3, 3);
    serve(32'h1010, 3, 3);
    rd_if.rd_ack  = 1'b1;
    rd_if.rd_done = 1'b1;
    tick(1);
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("s1_hold_noreq", 32'(rd_if.rd_req), 32'd0);
    end
    de_pulse();
    serve(32'h1020, 2, 2);
    de_pulse();
    serve(32'h1030, 2, 2);
    chk("s1_busy_end", 32'(busy), 32'd0);
    chk("s1_err", 32'(err_underflow), 32'd0);

    // 2+3: writer on 0 -> frame 2; first ack held off 10 cycles
    wr_frame_idx = 2'd0;
    vs_pulse();
    chk("s2_fidx", 32'(rd_frame_idx), 32'd2);
    serve(32'h1080, 10, 3);
    serve(32'h1090, 2, 2);
    de_pulse();
    serve(32'h10A0, 2, 2);
    de_pulse();
    serve(32'h10B0, 2, 2);
    chk("s2_busy_end", 32'(busy), 32'd0);
    de_pulse();
    de_pulse();
    chk("s2_err", 32'(err_underflow), 32'd0);

    // 4: de before any rd_done -> underflow; next vs clears the flag
    wr_frame_idx = 2'd2;
    vs_pulse();
    chk("s4_fidx", 32'(rd_frame_idx), 32'd1);
    de = 1'b1;
    tick(3);
    chk("s4_err_set", 32'(err_underflow), 32'd1);
`ifdef VLFC_UNDERFLOW_CNT_EN
    chk("s4_ucnt", 32'(underflow_cnt), 32'd1);
`endif
    de = 1'b0;
    tick(3);
    serve(32'h1040, 2, 2);
    serve(32'h1050, 2, 2);
    serve(32'h1060, 2, 2);
    tick(2);
    chk("s4_hold_noreq", 32'(rd_if.rd_req), 32'd0);
    chk("s4_err_sticky", 32'(err_underflow), 32'd1);
    wr_frame_idx = 2'd1;
    vs_pulse();
    chk("s4_err_clr", 32'(err_underflow), 32'd0);
    chk("s4_fidx2", 32'(rd_frame_idx), 32'd0);
    chk("s4_busy", 32'(busy), 32'd1);
`ifdef VLFC_UNDERFLOW_CNT_EN
    chk("s4_ucnt_kept", 32'(underflow_cnt), 32'd1);
`endif

    // 5: vs while line 2 request outstanding -> finish it, then restart
    serve(32'h1000, 2, 2);
    wait_req_chk(32'h1010);
    wr_frame_idx = 2'd0;
    vs_pulse();
    chk("s5_req_held", 32'(rd_if.rd_req), 32'd1);
    chk("s5_addr_held", 32'(rd_if.rd_addr), 32'h1010);
    chk("s5_fidx_old", 32'(rd_frame_idx), 32'd0);
    ack_after(1, 32'h1010);
    tick(3);
    chk("s5_wait_noreq", 32'(rd_if.rd_req), 32'd0);
    chk("s5_wait_fidx", 32'(rd_frame_idx), 32'd0);
    done_after(0);
    chk("s5_fidx_new", 32'(rd_frame_idx), 32'd2);
    serve(32'h1080, 2, 2);

    // 6: asynchronous reset while waiting for rd_done
    wait_req_chk(32'h1090);
    ack_after(0, 32'h1090);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_req", 32'(rd_if.rd_req), 32'd0);
    chk("s6_addr", 32'(rd_if.rd_addr), 32'h0);
    chk("s6_fidx", 32'(rd_frame_idx), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_err", 32'(err_underflow), 32'd0);
`ifdef VLFC_UNDERFLOW_CNT_EN
    chk("s6_ucnt", 32'(underflow_cnt), 32'd0);
`endif
    tick(1);
    rst_n = 1'b1;
    tick(2);
    wr_frame_idx = 2'd2;
    vs_pulse();
    chk("s6_fidx_new", 32'(rd_frame_idx), 32'd1);
    chk("s6_busy_new", 32'(busy), 32'd1);
    serve(32'h1040, 2, 2);
    serve(32'h1050, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_line_fetch_ctrl.md
Name: video_line_fetch_ctrl

Overview:
Per-line read scheduler for the display path. It sits between the video timing generator and the frame-buffer read channel, which feeds the pixel FIFO drained by the display delay/alignment stage. On each frame start it selects the last completed frame of a rotating buffer set. It then issues one burst read request per active line, keeping at most PREFETCH_LINES lines ahead of display consumption, and flags underflow.

Parameters:
ADDR_WIDTH, 24, word address width of rd_addr
LINE_WORDS, 1280, words per line; burst length and line stride
V_LINES, 720, active lines per frame
FRAME_NUM, 3, frame buffers in rotation (2..4)
FB_BASE, 0, word address of frame 0
PREFETCH_LINES, 2, max lines fetched but not yet consumed (1..3)

Ports:
video_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
vs  in  1  vertical sync from timing generator, active high
de  in  1  active video from timing generator, active high
wr_frame_idx  in  2  frame index the writer is currently filling
rd_req  out  1  burst read request; held until rd_ack
rd_addr  out  ADDR_WIDTH  burst start word address; stable while rd_req=1
rd_len  out  16  burst length in words; constant LINE_WORDS
rd_ack  in  1  one-cycle acceptance of the request
rd_done  in  1  one-cycle pulse when the accepted burst is fully in the FIFO
rd_frame_idx  out  2  frame index being displayed
busy  out  1  high from frame start until the last line's rd_done
err_underflow  out  1  sticky; set on underflow, cleared at next vs rising edge

Behaviour:
- Reset: rd_req=0, rd_addr=0, rd_frame_idx=0, busy=0, err_underflow=0, state IDLE, all counters 0. rd_len is always LINE_WORDS.
- vs and de are registered once. Edges are detected against the registered copy. An edge sampled at clock N takes effect at clock N+1.
- Frame start (vs rising edge):
  - rd_frame_idx <= (wr_frame_idx + FRAME_NUM - 1) mod FRAME_NUM.
  - frame_base <= FB_BASE + rd_frame_idx*LINE_WORDS*V_LINES, computed by repeated addition during a one-cycle LOAD state; no multiplier.
  - fetch_cnt=0, done_cnt=0, cons_cnt=0, busy=1, err_underflow=0.
- FSM:
  - IDLE -> LOAD on frame start.
  - LOAD -> REQ.
  - REQ: rd_req=1, rd_addr=frame_base+fetch_cnt*LINE_WORDS, using an incremental address register. On rd_ack: rd_req=0 on the next edge, fetch_cnt++, -> WAIT.
  - WAIT: on rd_done, done_cnt++. Then:
    - -> IDLE if fetch_cnt==V_LINES (busy=0);
    - else -> REQ if fetch_cnt - cons_cnt < PREFETCH_LINES;
    - else -> HOLD.
  - HOLD -> REQ once fetch_cnt - cons_cnt < PREFETCH_LINES.
- Consumption: each de falling edge increments cons_cnt, saturating at V_LINES.
- Underflow: a de rising edge with done_cnt <= cons_cnt sets err_underflow. Fetching continues unchanged.
- vs rising edge mid-frame:
  - rd_req high: hold rd_req and rd_addr until rd_ack, then wait for rd_done. Then apply the pending frame start and go to LOAD.
  - In WAIT: wait for rd_done, then apply the pending start.
  - In HOLD or IDLE: restart immediately.
  - Only one pending start is kept.
- rd_ack while rd_req=0 and rd_done outside WAIT are ignored.
- Reset mid-burst: all state cleared immediately. The read channel is reset by the same rst_n.
- Counter widths: clog2(V_LINES+1).

Optional Feature:
VLFC_UNDERFLOW_CNT_EN:
- Defined: adds output underflow_cnt[15:0]. It increments, saturating at 0xFFFF, on every underflow event. It is cleared only by rst_n, not by vs.
- Undefined: the port and counter are absent; only the sticky err_underflow exists.

Test Plan:
All scenarios use LINE_WORDS=16, V_LINES=4, FRAME_NUM=3, FB_BASE=0x1000, PREFETCH_LINES=2.
1. Reset, then vs pulse with wr_frame_idx=1 and rd_ack/rd_done after 3 cycles -> rd_frame_idx=0; rd_addr 0x1000 then 0x1010; then HOLD; no third request before the first de falling edge.
2. wr_frame_idx=0 at vs -> rd_frame_idx=2, first rd_addr=0x1000+2*64=0x1080; four lines from 4 de pulses give addresses 0x1080, 0x1090, 0x10A0, 0x10B0, then busy=0.
3. Hold rd_ack low 10 cycles -> rd_req and rd_addr stable throughout; after rd_ack, rd_req=0 next cycle.
4. de rising edge before first rd_done -> err_underflow=1 (underflow_cnt=1 with macro); next vs rising edge clears err_underflow but not underflow_cnt.
5. vs rising edge while rd_req=1 on line 2 -> request completes on rd_ack; after rd_done, new frame starts at line 0 with the new frame_base.
6. rst_n low during WAIT -> all outputs return to reset values asynchronously; the next vs restarts cleanly.
